// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: walks (h,v) over the full line/frame
// on each pixel clock-enable and registers sync, display-enable and strobes.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] xpos,
    output logic [CW-1:0] ypos,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Inclusive bounds keep every constant inside CW bits even when TOTAL == 2^CW.
    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_LAST = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] V_ACT_LAST = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] HS_FIRST   = CW'(H_ACTIVE + H_FRONT);
    localparam logic [CW-1:0] HS_LAST    = CW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST   = CW'(V_ACTIVE + V_FRONT);
    localparam logic [CW-1:0] VS_LAST    = CW'(V_ACTIVE + V_FRONT + V_SYNC - 1);

    logic [CW-1:0] r_h;
    logic [CW-1:0] r_v;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_de;
    logic          r_line_start;
    logic          r_frame_start;

    logic [CW-1:0] w_h_next;
    logic [CW-1:0] w_v_next;
    logic          w_h_wrap;

    function automatic logic f_sync(input logic [CW-1:0] pos,
                                    input logic [CW-1:0] first,
                                    input logic [CW-1:0] last,
                                    input logic          pol);
        return (pos >= first && pos <= last) ? pol : ~pol;
    endfunction

    function automatic logic f_de(input logic [CW-1:0] h, input logic [CW-1:0] v);
        return (h <= H_ACT_LAST) && (v <= V_ACT_LAST);
    endfunction

    always_comb begin
        w_h_wrap = (r_h == H_LAST);
        w_h_next = w_h_wrap ? '0 : r_h + CW'(1);
        w_v_next = r_v;
        if (w_h_wrap) begin
            w_v_next = (r_v == V_LAST) ? '0 : r_v + CW'(1);
        end
    end

    // Outputs are computed from the next position so they land in the same
    // cycle as the coordinates they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h           <= '0;
            r_v           <= '0;
            r_hsync       <= f_sync('0, HS_FIRST, HS_LAST, HS_POL);
            r_vsync       <= f_sync('0, VS_FIRST, VS_LAST, VS_POL);
            r_de          <= f_de('0, '0);
            r_line_start  <= 1'b1;
            r_frame_start <= 1'b1;
        end else if (ce) begin
            r_h           <= w_h_next;
            r_v           <= w_v_next;
            r_hsync       <= f_sync(w_h_next, HS_FIRST, HS_LAST, HS_POL);
            r_vsync       <= f_sync(w_v_next, VS_FIRST, VS_LAST, VS_POL);
            r_de          <= f_de(w_h_next, w_v_next);
            r_line_start  <= (w_h_next == '0);
            r_frame_start <= (w_h_next == '0) && (w_v_next == '0);
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign xpos        = r_h;
    assign ypos        = r_v;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule
